// File: rtl/button_input_conditioner.sv
// rtl/button_input_conditioner.sv - multi-channel button sync, debounce, edge pulses and auto-repeat
module button_input_conditioner #(
   parameter int             NUM_BTN       = 5,
   parameter int             STABLE_CYCLES = 4,
   parameter int             REPEAT_DELAY  = 30,
   parameter int             REPEAT_RATE   = 8,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK = 5'b11110,
   parameter int             CNT_W         = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic               enable,
   output logic [NUM_BTN-1:0] clean,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic [NUM_BTN-1:0] release_pulse,
   output logic [NUM_BTN-1:0] action_pulse,
   output logic               any_held
);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(REPEAT_RATE - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;
   logic [NUM_BTN-1:0] w_rise;
   logic [NUM_BTN-1:0] w_fall;
   logic [NUM_BTN-1:0] w_fire;
   logic [NUM_BTN-1:0] r_press;
   logic [NUM_BTN-1:0] r_release;
   logic [NUM_BTN-1:0] r_action;

   // Two-flop synchroniser for the asynchronous pin levels
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      logic             r_clean;
      logic [CNT_W-1:0] r_db_cnt;
      logic             w_differ;
      logic             w_db_done;

      assign w_differ  = r_sync2[g] ^ r_clean;
      // The edge on which clean flips; pulses and the repeat FSM key off this
      assign w_db_done = w_differ && (r_db_cnt == STABLE_LAST);
      assign w_rise[g] = w_db_done & ~r_clean;
      assign w_fall[g] = w_db_done &  r_clean;
      assign clean[g]  = r_clean;

      // Debounce: any cycle agreeing with clean restarts the stability count
      always_ff @(posedge clk) begin
         if (reset) begin
            r_clean  <= 1'b0;
            r_db_cnt <= '0;
         end else if (!w_differ) begin
            r_db_cnt <= '0;
         end else if (w_db_done) begin
            r_clean  <= r_sync2[g];
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + CNT_W'(1);
         end
      end

      if (REPEAT_MASK[g]) begin : g_rep
         logic [1:0]       r_state;
         logic [CNT_W-1:0] r_rp_cnt;

         // A release on the same edge wins over a due repeat
         assign w_fire[g] = enable && !w_fall[g] &&
                            (((r_state == ST_DELAY)  && (r_rp_cnt == DELAY_LAST)) ||
                             ((r_state == ST_REPEAT) && (r_rp_cnt == RATE_LAST)));

         // Repeat FSM: edges of clean always move the state, timing only runs while enabled
         always_ff @(posedge clk) begin
            if (reset) begin
               r_state  <= ST_IDLE;
               r_rp_cnt <= '0;
            end else if (w_fall[g]) begin
               r_state  <= ST_IDLE;
               r_rp_cnt <= '0;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     r_rp_cnt <= '0;
                     if (w_rise[g]) r_state <= ST_DELAY;
                  end
                  ST_DELAY: begin
                     if (!enable) begin
                        r_rp_cnt <= '0;
                     end else if (r_rp_cnt == DELAY_LAST) begin
                        r_state  <= ST_REPEAT;
                        r_rp_cnt <= '0;
                     end else begin
                        r_rp_cnt <= r_rp_cnt + CNT_W'(1);
                     end
                  end
                  ST_REPEAT: begin
                     if (!enable || (r_rp_cnt == RATE_LAST)) r_rp_cnt <= '0;
                     else                                    r_rp_cnt <= r_rp_cnt + CNT_W'(1);
                  end
                  default: begin
                     r_state  <= ST_IDLE;
                     r_rp_cnt <= '0;
                  end
               endcase
            end
         end
      end else begin : g_norep
         assign w_fire[g] = 1'b0;
      end
   end

   // Registered pulse outputs, all gated by enable
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_press   <= '0;
         r_release <= '0;
         r_action  <= '0;
      end else begin
         r_press   <= w_rise;
         r_release <= w_fall;
         r_action  <= w_rise | w_fire;
      end
   end

   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign action_pulse  = r_action;
   assign any_held      = |clean;

endmodule

// File: tb/tb_button_input_conditioner.sv
// tb/tb_button_input_conditioner.sv - scoreboard bench for button_input_conditioner
module tb_button_input_conditioner;

   localparam int NB = 5;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_ACT   = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic          enable = 1'b1;
   logic [NB-1:0] clean;
   logic [NB-1:0] press_pulse;
   logic [NB-1:0] release_pulse;
   logic [NB-1:0] action_pulse;
   logic          any_held;

   button_input_conditioner dut (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw),
      .enable        (enable),
      .clean         (clean),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .action_pulse  (action_pulse),
      .any_held      (any_held)
   );

   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc is the index of the most recent rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Event key = edge*100 + kind*10 + channel, kept sorted
   task automatic push_ev(input int c, input int kind, input int ch);
      int key;
      int i;
      key = c * 100 + kind * 10 + ch;
      i = 0;
      while (i < q.size() && q[i] < key) i++;
      q.insert(i, key);
   endtask

   task automatic push_press(input int c, input int ch);
      push_ev(c, K_PRESS, ch);
      push_ev(c, K_ACT, ch);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Every observed pulse is matched against the head of the scoreboard
   always @(negedge clk) begin
      logic [NB-1:0] v;
      for (int k = 0; k < 3; k++) begin
         v = (k == K_PRESS) ? press_pulse : (k == K_REL) ? release_pulse : action_pulse;
         for (int ch = 0; ch < NB; ch++) begin
            if (v[ch]) begin
               if (q.size() == 0) check_eq("unexpected_pulse", cyc * 100 + k * 10 + ch, -1);
               else               check_eq("pulse_event", cyc * 100 + k * 10 + ch, q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      wait_until(3);
      check_eq("rst_clean",   int'(clean), 0);
      check_eq("rst_press",   int'(press_pulse), 0);
      check_eq("rst_release", int'(release_pulse), 0);
      check_eq("rst_action",  int'(action_pulse), 0);
      check_eq("rst_any",     int'(any_held), 0);
      reset = 1'b0;

      // Clean press on up: stable before edge 10, registered at edge 15
      wait_until(9);
      btn_raw[1] = 1'b1;
      push_press(15, 1);
      wait_until(14);
      check_eq("s1_clean_pre", int'(clean[1]), 0);
      wait_until(15);
      check_eq("s1_clean", int'(clean[1]), 1);
      check_eq("s1_any",   int'(any_held), 1);
      wait_until(16);
      check_eq("s1_press_low", int'(press_pulse[1]), 0);
      wait_until(20);
      btn_raw[1] = 1'b0;
      push_ev(26, K_REL, 1);
      wait_until(27);
      check_eq("s1_clean_rel", int'(clean[1]), 0);
      wait_until(30);
      check_eq("s1_left", q.size(), 0);

      // Glitch of 3 cycles on right is rejected, a longer hold is accepted
      wait_until(40);
      btn_raw[3] = 1'b1;
      wait_until(43);
      btn_raw[3] = 1'b0;
      wait_until(55);
      check_eq("s2_glitch_clean", int'(clean[3]), 0);
      wait_until(60);
      btn_raw[3] = 1'b1;
      push_press(66, 3);
      wait_until(70);
      btn_raw[3] = 1'b0;
      push_ev(76, K_REL, 3);
      wait_until(80);
      check_eq("s2_clean_rel", int'(clean[3]), 0);
      check_eq("s2_left", q.size(), 0);

      // Auto-repeat on down: P, P+30, P+38, P+46, then release
      wait_until(90);
      btn_raw[2] = 1'b1;
      push_press(96, 2);
      push_ev(126, K_ACT, 2);
      push_ev(134, K_ACT, 2);
      push_ev(142, K_ACT, 2);
      wait_until(140);
      btn_raw[2] = 1'b0;
      push_ev(146, K_REL, 2);
      wait_until(170);
      check_eq("s3_left", q.size(), 0);

      // Centre is masked (single action), left repeats alongside it
      wait_until(180);
      btn_raw[0] = 1'b1;
      btn_raw[4] = 1'b1;
      push_press(186, 0);
      push_press(186, 4);
      for (int k = 0; k < 9; k++) push_ev(186 + 30 + 8 * k, K_ACT, 4);
      wait_until(280);
      btn_raw[0] = 1'b0;
      btn_raw[4] = 1'b0;
      push_ev(286, K_REL, 0);
      push_ev(286, K_REL, 4);
      wait_until(290);
      check_eq("s4_clean", int'(clean), 0);
      wait_until(300);
      check_eq("s4_left", q.size(), 0);

      // Press while disabled: clean tracks, no pulses; repeat timing restarts at enable
      wait_until(310);
      enable = 1'b0;
      btn_raw[1] = 1'b1;
      wait_until(317);
      check_eq("s5_clean", int'(clean[1]), 1);
      check_eq("s5_any",   int'(any_held), 1);
      wait_until(320);
      enable = 1'b1;
      push_ev(350, K_ACT, 1);
      push_ev(358, K_ACT, 1);
      wait_until(353);
      btn_raw[1] = 1'b0;
      push_ev(359, K_REL, 1);
      wait_until(375);
      check_eq("s5_left", q.size(), 0);

      // One-cycle reset during a repeating hold on down restarts everything
      wait_until(380);
      btn_raw[2] = 1'b1;
      push_press(386, 2);
      push_ev(416, K_ACT, 2);
      wait_until(419);
      reset = 1'b1;
      wait_until(420);
      check_eq("s6_rst_clean",   int'(clean), 0);
      check_eq("s6_rst_any",     int'(any_held), 0);
      check_eq("s6_rst_press",   int'(press_pulse), 0);
      check_eq("s6_rst_release", int'(release_pulse), 0);
      check_eq("s6_rst_action",  int'(action_pulse), 0);
      reset = 1'b0;
      // First edge with reset low is 421; full sync + debounce latency gives 426
      push_press(426, 2);
      wait_until(430);
      btn_raw[2] = 1'b0;
      push_ev(436, K_REL, 2);
      wait_until(450);
      check_eq("s6_left", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
